// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch stage. It captures the fetch
//   address, reads a word from an internal loadable array after WAIT_STATES
//   extra cycles and returns it to decode. While a read is outstanding the
//   fetch stage is held with stall_o. A redirect (flush_i) aborts the
//   in-flight read. Misaligned and out-of-range addresses return a fault
//   with a zero instruction word.
//
// Parameters
//   WAIT_STATES  extra cycles per read, 0..15
//   DEPTH_WORDS  number of 32-bit words, power of two, >= 2
//
// Ports
//   clk                    clock, rising edge
//   reset                  asynchronous reset, active low
//   req_i                  fetch request valid
//   instruction_address_i  fetch byte address
//   flush_i                redirect, aborts the in-flight read
//   load_we_i              loader write enable
//   load_addr_i            loader byte address (bits [1:0] ignored)
//   load_data_i            loader write data
//   stall_o                holds the fetch stage (state decode)
//   instruction_o          returned instruction word (registered)
//   instruction_valid_o    one-cycle response pulse (registered)
//   fault_o                response fault flag (registered)
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] instruction_address_i,
    input  logic        flush_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        stall_o,
    output logic [31:0] instruction_o,
    output logic        instruction_valid_o,
    output logic        fault_o
);

    localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned DW     = 32;
    localparam int unsigned CW     = 4;
    localparam logic [CW-1:0] WAIT_N = CW'(WAIT_STATES);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_WAIT  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          rsp_fault_q, rsp_fault_d;

    // Word array; deliberately has no reset.
    logic [DW-1:0] mem [DEPTH_WORDS];

    // Request decode: word index (wrapped into the array) and fault flag.
    logic [AW-1:0] req_idx;
    logic          req_fault;
    logic [AW-1:0] load_idx;

    assign req_idx   = instruction_address_i[AW+1:2];
    assign req_fault = (instruction_address_i[1:0] != 2'b00)
                    || (32'(instruction_address_i[31:2]) >= 32'(DEPTH_WORDS));
    assign load_idx  = load_addr_i[AW+1:2];

    // Loader bits outside the word index carry no information.
    if (AW < 30) begin : g_load_hi
        logic unused_load_bits;
        assign unused_load_bits = ^{load_addr_i[1:0], load_addr_i[31:AW+2]};
    end else begin : g_load_lo
        logic unused_load_bits;
        assign unused_load_bits = ^load_addr_i[1:0];
    end

    // Read data for the two response points; a faulting access returns zero.
    logic [DW-1:0] acc_rdata;
    logic [DW-1:0] wait_rdata;

    assign acc_rdata  = req_fault ? '0 : mem[req_idx];
    assign wait_rdata = fault_q   ? '0 : mem[addr_q];

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        fault_d     = fault_q;
        instr_d     = instr_q;
        rsp_fault_d = rsp_fault_q;
        valid_d     = 1'b0;

        case (state_q)
            ST_READY: begin
                if (req_i && !flush_i) begin
                    addr_d  = req_idx;
                    fault_d = req_fault;
                    if (WAIT_N == '0) begin
                        // Zero wait states: respond on the accept edge.
                        valid_d     = 1'b1;
                        instr_d     = acc_rdata;
                        rsp_fault_d = req_fault;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_N;
                    end
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    // Redirect wins over a response due on this edge.
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    valid_d     = 1'b1;
                    instr_d     = wait_rdata;
                    rsp_fault_d = fault_q;
                    state_d     = ST_READY;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_READY;
            cnt_q       <= '0;
            addr_q      <= '0;
            fault_q     <= 1'b0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            fault_q     <= fault_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Loader write port; reads above see the pre-edge contents.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_idx] <= load_data_i;
        end
    end

    assign stall_o             = (state_q == ST_WAIT);
    assign instruction_o       = instr_q;
    assign instruction_valid_o = valid_q;
    assign fault_o             = rsp_fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Four responders (WAIT_STATES 0, 2, 3, 4) share one input stream. A
//   reference model tracks each responder as "idle" or "busy until edge E"
//   and pushes the expected response into a scoreboard when it falls due.
//   A forked monitor pops and compares whenever a responder shows a valid.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    localparam int NI    = 4;
    localparam int DEPTH = 64;

    typedef struct {
        int          inst;
        int          edge_no;
        logic [31:0] data;
        logic        flt;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        tb_req;
    logic [31:0] tb_addr;
    logic        tb_flush;
    logic        tb_we;
    logic [31:0] tb_laddr;
    logic [31:0] tb_ldata;

    logic [NI-1:0] stall_w;
    logic [NI-1:0] valid_w;
    logic [NI-1:0] fault_w;
    logic [31:0]   instr_w [NI];

    int          n_cmp;
    int          n_err;
    int          edge_cnt;
    exp_t        sb_q[$];
    logic [31:0] mem_m [DEPTH];
    int          ns_tab [NI] = '{0, 2, 3, 4};
    bit          busy [NI];
    int          due [NI];
    int unsigned pend_idx [NI];
    bit          pend_flt [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned NS = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
        imem_responder #(
            .WAIT_STATES (NS),
            .DEPTH_WORDS (DEPTH)
        ) u_dut (
            .clk                   (clk),
            .reset                 (reset_n),
            .req_i                 (tb_req),
            .instruction_address_i (tb_addr),
            .flush_i               (tb_flush),
            .load_we_i             (tb_we),
            .load_addr_i           (tb_laddr),
            .load_data_i           (tb_ldata),
            .stall_o               (stall_w[g]),
            .instruction_o         (instr_w[g]),
            .instruction_valid_o   (valid_w[g]),
            .fault_o               (fault_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d (ws=%0d) edge %0d: got %h expected %h",
                     name, inst, ns_tab[inst], edge_cnt, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int unsigned idx, input bit flt);
        return flt ? 32'h0 : mem_m[idx];
    endfunction

    // Reference model for the edge that just happened, using the inputs held
    // during the preceding cycle.
    task automatic model_edge();
        int unsigned idx;
        bit          flt;
        edge_cnt++;
        for (int k = 0; k < NI; k++) begin
            if (!reset_n) begin
                busy[k] = 1'b0;
            end else if (busy[k]) begin
                if (tb_flush) begin
                    busy[k] = 1'b0;
                end else if (edge_cnt == due[k]) begin
                    sb_q.push_back('{k, edge_cnt, model_read(pend_idx[k], pend_flt[k]), pend_flt[k]});
                    busy[k] = 1'b0;
                end
            end else if (tb_req && !tb_flush) begin
                idx = (tb_addr / 4) % DEPTH;
                flt = (tb_addr % 4 != 0) || (tb_addr / 4 >= DEPTH);
                if (ns_tab[k] == 0) begin
                    sb_q.push_back('{k, edge_cnt, model_read(idx, flt), flt});
                end else begin
                    busy[k]     = 1'b1;
                    due[k]      = edge_cnt + ns_tab[k];
                    pend_idx[k] = idx;
                    pend_flt[k] = flt;
                end
            end
        end
        if (reset_n && tb_we) begin
            mem_m[(tb_laddr / 4) % DEPTH] = tb_ldata;
        end
    endtask

    task automatic cycle(input logic rq, input logic [31:0] a, input logic fl,
                         input logic we, input logic [31:0] la, input logic [31:0] ld);
        tb_req   = rq;
        tb_addr  = a;
        tb_flush = fl;
        tb_we    = we;
        tb_laddr = la;
        tb_ldata = ld;
        @(posedge clk);
        #1;
        model_edge();
        for (int k = 0; k < NI; k++) begin
            chk("stall", k, 32'(stall_w[k]), 32'(busy[k]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic req(input logic [31:0] a);
        cycle(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < NI; k++) begin
            chk("rst_valid", k, 32'(valid_w[k]), 32'h0);
            chk("rst_instr", k, instr_w[k], 32'h0);
            chk("rst_fault", k, 32'(fault_w[k]), 32'h0);
            chk("rst_stall", k, 32'(stall_w[k]), 32'h0);
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle.
    task automatic do_reset(input int hold);
        #1 reset_n = 1'b0;
        #1;
        sb_q.delete();
        for (int k = 0; k < NI; k++) busy[k] = 1'b0;
        check_reset_outputs();
        idle(hold);
        #1 reset_n = 1'b1;
    endtask

    task automatic monitor_loop();
        int   pos;
        bit   exp_v;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                pos = -1;
                for (int j = 0; j < sb_q.size(); j++) begin
                    if (pos < 0 && sb_q[j].inst == k) pos = j;
                end
                exp_v = (pos >= 0) && (sb_q[pos].edge_no <= edge_cnt);
                chk("valid", k, 32'(valid_w[k]), 32'(exp_v));
                if (exp_v) begin
                    e = sb_q[pos];
                    sb_q.delete(pos);
                    if (valid_w[k]) begin
                        chk("instr", k, instr_w[k], e.data);
                        chk("fault", k, 32'(fault_w[k]), 32'(e.flt));
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        return $urandom();
    endfunction

    initial begin
        logic [31:0] a;
        n_cmp    = 0;
        n_err    = 0;
        edge_cnt = 0;
        tb_req   = 1'b0;
        tb_addr  = '0;
        tb_flush = 1'b0;
        tb_we    = 1'b0;
        tb_laddr = '0;
        tb_ldata = '0;
        for (int k = 0; k < NI; k++) begin
            busy[k] = 1'b0;
            due[k]  = 0;
        end
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        fork
            monitor_loop();
        join_none
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Preload the whole array.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       a = 32'h0000_0013;
                1:       a = 32'h0000_0093;
                2:       a = 32'h0000_0113;
                3:       a = 32'h0000_0193;
                4:       a = 32'hDEAD_BEEF;
                8:       a = 32'h0808_0808;
                default: a = $urandom();
            endcase
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'(i) << 2, a);
        end
        idle(1);

        // Back-to-back fetches.
        req(32'h0); req(32'h4); req(32'h8); req(32'hC);
        idle(6);

        // Wait-state read of 0xDEADBEEF.
        req(32'h10);
        idle(6);

        // Flush in the second wait cycle, then an immediate new request.
        req(32'h40);
        idle(1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        req(32'h20);
        idle(6);

        // Misaligned and out-of-range fetches.
        req(32'h6);
        idle(6);
        req(32'(DEPTH * 4));
        idle(6);

        // Reset in the second wait cycle.
        req(32'h30);
        idle(1);
        do_reset(2);
        idle(6);

        // Loader writes the in-flight word during the wait.
        req(32'h50);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h50, 32'hCAFE_F00D);
        idle(6);
        // Same-edge write and zero-wait read return the old word.
        cycle(1'b1, 32'h54, 1'b0, 1'b1, 32'h57, 32'h1234_5678);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            a = rand_addr();
            cycle(1'($urandom_range(0, 9) < 7), a, 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 1) == 1) ? a : $urandom(), $urandom());
            if ($urandom_range(0, 299) == 0) do_reset(1);
        end
        idle(8);
        chk("sb_empty", 0, 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the fetch stage. It samples the fetch unit's instruction address, reads a word from an internal loadable memory after a configurable number of wait states, and returns the instruction to decode. While a read is in progress it holds the fetch stage with `stall_o`. It aborts the in-flight read on a pipeline redirect, and flags misaligned or out-of-range addresses.

## Interface
Parameters:
- `WAIT_STATES`, default 1: extra cycles per read. Legal range is 0..15.
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  the single clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_i`  in  1  fetch request valid.
- `instruction_address_i`  in  32  byte address from the fetch stage.
- `flush_i`  in  1  redirect (jump, exception, mret); aborts the in-flight read.
- `load_we_i`  in  1  loader write enable.
- `load_addr_i`  in  32  loader byte address; bits [1:0] are ignored.
- `load_data_i`  in  32  loader write data.
- `stall_o`  out  1  holds the fetch stage.
- `instruction_o`  out  32  returned instruction word.
- `instruction_valid_o`  out  1  one-cycle pulse; `instruction_o` is valid in that cycle.
- `fault_o`  out  1  the returned access was misaligned or out of range; qualified by `instruction_valid_o`.

## Operation
- State machine states: `READY` and `WAIT`.
- Internal registers:
  - `addr_q`, the captured word index.
  - `fault_q`, the captured fault flag.
  - `cnt_q`, a 4-bit down-counter.
- **Accept:** a request is accepted in a cycle where the state is `READY`, `req_i`=1 and `flush_i`=0. On accept:
  - `addr_q` ← `instruction_address_i[31:2]` modulo `DEPTH_WORDS`.
  - `fault_q` ← (`instruction_address_i[1:0]` != 0) OR (`instruction_address_i[31:2]` >= `DEPTH_WORDS`).
- **WAIT_STATES = 0:** the state never leaves `READY`. The response is registered on the accept edge: `instruction_valid_o`=1, `instruction_o` = mem[index], `fault_o` = fault. This permits back-to-back accepts every cycle.
- **WAIT_STATES = N > 0:** on accept, the state goes to `WAIT` and `cnt_q` ← N.
  - In `WAIT`, `cnt_q` decrements each cycle.
  - On the edge where `cnt_q`=1, the response is registered: `instruction_valid_o`=1, `instruction_o` = mem[`addr_q`], `fault_o` = `fault_q`. The state returns to `READY`.
- **Fault response:** `instruction_o` = 32'h0000_0000. No array read is used.
- **`stall_o`:** equals (state == `WAIT`), decoded directly from the state register with no input dependency.
- **`instruction_valid_o`:** defaults to 0 on every edge with no response. `instruction_o` and `fault_o` hold their last values.
- **Flush:**
  - `flush_i`=1 in `WAIT`: the state goes to `READY`, `cnt_q` ← 0, and no response is produced, even if `cnt_q`=1 in that cycle.
  - `flush_i`=1 in `READY`: no accept. A response registered by a previous edge is not retracted.
- **Loader:** when `load_we_i`=1, mem[`load_addr_i[31:2]` mod `DEPTH_WORDS`] ← `load_data_i`. This happens in any state.
  - A read and a write to the same word on the same edge return the old data (read-before-write).
  - A write made during `WAIT`, before the response edge, is visible in the response.
- **Array:** the memory array is not reset.
- **Reset (asynchronous):** state ← `READY`, `cnt_q` ← 0, `addr_q` ← 0, `fault_q` ← 0, `instruction_o` ← 0, `instruction_valid_o` ← 0, `fault_o` ← 0, and therefore `stall_o` = 0. Reset asserted during `WAIT` drops the read with no response after release.

## Timing
- **Latency:** accept at edge t; response visible after edge t+N (N = `WAIT_STATES`). For N=0 it is visible in the cycle after t.
- **`stall_o`:** 0 in the accept cycle; 1 for exactly N cycles after it; 0 in the cycle where `instruction_valid_o`=1.
- **Throughput:** one instruction per N+1 cycles. The next accept is possible in the response cycle.
- **Outputs:** all outputs are registered or pure state decodes. No combinational path from any input to any output.

## Test plan
1. **Back-to-back fetch, N=0:**
   - Stimulus: preload mem[0..3] = 0x13, 0x93, 0x113, 0x193; drive addresses 0, 4, 8, 12 on consecutive cycles with `req_i`=1.
   - Required: `instruction_valid_o`=1 for 4 consecutive cycles returning those words in order; `stall_o` never 1.
2. **Wait states, N=2:**
   - Stimulus: read address 0x10 holding 0xDEADBEEF.
   - Required: `stall_o`=1 for exactly 2 cycles; `instruction_valid_o` pulses once, in the following cycle, with 0xDEADBEEF and `fault_o`=0.
3. **Flush during WAIT, N=3:**
   - Stimulus: assert `flush_i` in the second `WAIT` cycle.
   - Required: no valid pulse; `stall_o`=0 in the next cycle; a new request to 0x20 is accepted immediately and returns mem[8].
4. **Faults:**
   - Stimulus: address 0x6 (misaligned); separately, address 4*`DEPTH_WORDS` (out of range).
   - Required: each returns `instruction_valid_o`=1, `fault_o`=1, `instruction_o`=0.
5. **Reset mid-read, N=4:**
   - Stimulus: drive `reset`=0 asynchronously in the second `WAIT` cycle; release it.
   - Required: all outputs 0 immediately; no response after release.
6. **Loader hazard, N=2:**
   - Stimulus: write 0xCAFEF00D to the in-flight word during `WAIT`.
   - Required: the response is 0xCAFEF00D. With N=0, a same-edge write and read returns the old word.
